add32_seq: RTL and testbench
============================

# add32_seq

Byte-serial multi-byte adder sequencer for projectALU. It latches two (8·NBYTES)-bit operands on `start`. It then drives one `adder8` instance with one operand byte per cycle, LSB first, and registers the `adder8` carry-out as the carry-in for the next byte. The block sits directly around the 8-bit adder: it feeds the adder's `a`/`b`/`cin` and consumes its `sum`/`cout`. This gives the ALU wide addition without a wide carry chain.

## Interface
Parameters:
- `NBYTES`, default 4: number of bytes. Operand width W = 8·NBYTES. Legal range 2..16.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request; accepted only when `busy`=0.
- `a`, input, W: operand A; sampled on the accepting edge.
- `b`, input, W: operand B; sampled on the accepting edge.
- `cin`, input, 1: initial carry-in; sampled on the accepting edge.
- `sub`, input, 1: subtract request; sampled on the accepting edge. Present only with `ADD32_SEQ_SUB_EN`.
- `busy`, output, 1: operation in progress.
- `done`, output, 1: one-cycle pulse; result outputs are valid from this cycle.
- `sum`, output, W: result; holds until the next completion.
- `cout`, output, 1: carry out of the MSB byte.
- `ovf`, output, 1: two's-complement signed overflow of the W-bit result.

## Operation
- FSM states IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE with `start`=1:
  - Latch `a`, `b` and the carry register (cin).
  - Clear byte counter `k`.
  - Go to RUN.
- RUN:
  - `adder8` inputs: `a=A[8k+7:8k]`, `b=B[8k+7:8k]`, `cin=carry_reg`.
  - Each edge: write the adder's `sum` into byte k of the internal accumulator, load `carry_reg` with the adder's `cout`, then `k++`.
  - At the edge that processes `k`=NBYTES-1: copy the full accumulator (including the final byte) to `sum`, final cout to `cout`, compute `ovf`, go to DONE.
- DONE: lasts exactly one cycle, then IDLE unless `start`=1 (back-to-back accepted).
- `start` in RUN is ignored, not queued.
- `ovf` = (A[W-1] == Beff[W-1]) && (sum[W-1] != A[W-1]). Beff is the B value actually presented to the adder.
- `sum`, `cout`, `ovf` change only at completion. Partial results are never visible on them.
- Counter width is `$clog2(NBYTES)`; `k` never wraps during an operation.

## Timing
- Reset values, applied asynchronously and held while `rst_n`=0: `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0; state IDLE; `k`=0; carry register 0.
- Reset asserted mid-operation: the partial result is discarded and no `done` is produced.
- Latency:
  - `start` accepted at edge T.
  - `busy`=1 from after edge T until edge T+NBYTES.
  - `done`=1 and results updated after edge T+NBYTES, for one cycle.
  - Throughput: one operation per NBYTES+1 cycles with back-to-back `start`.
- `busy` and `done` are never high together.
- `start` held high continuously: a new operation is accepted in every DONE cycle.

## Configuration
- `ADD32_SEQ_SUB_EN` defined:
  - `sub` port exists.
  - `sub`=1 latches Beff = ~b and forces the initial carry to 1, ignoring `cin`; the result is a − b.
  - `cout`=1 means no borrow.
  - `ovf` uses the inverted B.
- `ADD32_SEQ_SUB_EN` undefined: no `sub` port; Beff = b always.

## Test plan
All with NBYTES=4.
- Carry propagation: a=0x000000FF, b=0x00000001, cin=0, `start` at edge T -> `done` after edge T+4; sum=0x00000100, cout=0, ovf=0.
- Full wrap: a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, cout=1, ovf=0. Also cin=1 with a=b=0 -> sum=0x00000001.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1. Also a=b=0x80000000 -> sum=0, cout=1, ovf=1.
- Handshake:
  - Pulse `start` with new operands in RUN cycle 2 -> ignored; the first result is unchanged and `done` fires once.
  - `start` held high across DONE -> second operation accepted and completes 5 cycles later.
- Reset mid-operation: drop `rst_n` in RUN cycle 2 -> outputs read 0 immediately (asynchronously); no `done`. Next `start` completes normally.
- Subtraction, with `ADD32_SEQ_SUB_EN` defined:
  - sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.

Source files
------------

// File: rtl/add32_seq.sv
// add32_seq: byte-serial W-bit adder around a single adder8; define ADD32_SEQ_SUB_EN to add the sub port (a - b).
module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

module add32_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
`ifdef ADD32_SEQ_SUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                ovf
);
  localparam int W = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);
  localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, c8, sub_eff;
  logic [W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [7:0] s8;
`ifdef ADD32_SEQ_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif
  adder8 u_add (
    .a(a_q[{k_q, 3'b000} +: 8]),
    .b(b_q[{k_q, 3'b000} +: 8]),
    .cin(carry_q),
    .sum(s8),
    .cout(c8)
  );
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    carry_d = carry_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    sum_d = sum_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    if (state_q == RUN) begin
      acc_d[{k_q, 3'b000} +: 8] = s8;
      carry_d = c8;
      k_d = (k_q == KLAST) ? '0 : k_q + KW'(1);
      if (k_q == KLAST) begin
        state_d = DONE;
        sum_d = acc_d;
        cout_d = c8;
        ovf_d = (a_q[W-1] == b_q[W-1]) && (acc_d[W-1] != a_q[W-1]);
      end
    end else if (start) begin
      state_d = RUN;
      a_d = a;
      b_d = sub_eff ? ~b : b;
      carry_d = sub_eff | cin;
      k_d = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      carry_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      carry_q <= carry_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_add32_seq.sv
// tb_add32_seq: directed and random checks of add32_seq (NBYTES=4) against an arithmetic model.
module tb_add32_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [31:0] a = '0, b = '0, sum;
  logic busy, done, cout, ovf;
`ifdef ADD32_SEQ_SUB_EN
  logic sub = 1'b0;
`endif
  int total = 0, bad = 0;
  logic [31:0] e_sum;
  logic e_cout, e_ovf;

  add32_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef ADD32_SEQ_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint u, r;
    u = s ? ux - uy : ux + uy + longint'(c);
    r = s ? sx - sy : sx + sy + longint'(c);
    e_sum = u[31:0];
    e_cout = s ? (ux >= uy) : (u >= 64'h1_0000_0000);
    e_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s, input logic hold);
    a = x;
    b = y;
    cin = c;
`ifdef ADD32_SEQ_SUB_EN
    sub = s;
`endif
    model(x, y, c, s);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = hold;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      assert (!(busy && done)) else $error("FAIL busy_and_done");
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sum"}, sum, e_sum);
    chk({tag, "_cout"}, cout, e_cout);
    chk({tag, "_ovf"}, ovf, e_ovf);
  endtask

  task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
    int n;
    launch(x, y, c, s, 1'b0);
    chk({tag, "_busy_run"}, busy, 1);
    wait_done(n);
    chk({tag, "_latency"}, n, 4);
    check_result(tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n, seen;
    logic [31:0] ra, rb;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op("carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    op("cin1", 32'h0, 32'h0, 1'b1, 1'b0);
    op("povf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    op("novf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = ~ra;
      op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check_result("ignore");
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      seen += int'(done);
    end
    chk("ignore_single_done", seen, 0);
    launch(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0, 1'b1);
    wait_done(n);
    check_result("held1");
    a = 32'hA5A5_A5A5;
    b = 32'h5A5A_5A5B;
    cin = 1'b0;
    model(a, b, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("held2_busy", busy, 1);
    wait_done(n);
    chk("held2_latency", n, 4);
    check_result("held2");
    @(posedge clk);
    #1;
    launch(32'h0123_4567, 32'h89AB_CDEF, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sum", sum, 0);
    chk("arst_cout", cout, 0);
    chk("arst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      seen += int'(done) + int'(busy);
    end
    chk("arst_no_done", seen, 0);
    op("after_rst", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
`ifdef ADD32_SEQ_SUB_EN
    op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1);
    op("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1);
    op("sub_cin_ignored", 32'd9, 32'd9, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) op("sub_rand", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
